pipe_pwr_rate_ctrl: RTL and testbench

- MAC-side sequencer for the PIPE power-state, rate and receiver-detect handshakes.
- Accepts one command at a time from the LTSSM and drives the PIPE control signals power_down, rate, tx_detect_rx and tx_elec_idle.
- Waits for the PHY's phy_status completion pulse, then returns a one-cycle response.
- Also tracks PHY readiness after reset: phy_status high until the PHY PLL is stable.

---
 rtl/pipe_pwr_rate_ctrl_pkg.sv | 39 +++
 rtl/pipe_pwr_rate_ctrl_if.sv | 34 +++
 rtl/pipe_pwr_rate_ctrl_timeout.sv | 34 +++
 rtl/pipe_pwr_rate_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipe_pwr_rate_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pwr_rate_ctrl_pkg.sv
// Shared types for the PIPE power/rate/detect sequencer.
// Provides power-state and command encodings, the receiver-present rx_status code
// and the sequencer state enum.
package pipe_pkg;

    // PIPE PowerDown encodings, as driven on the 4-bit power_down bus.
    typedef enum logic [3:0] {
        P0  = 4'd0,
        P0S = 4'd1,
        P1  = 4'd2,
        P2  = 4'd3
    } pipe_pd_t;

    // LTSSM command opcodes; OP_RSVD is always rejected.
    typedef enum logic [1:0] {
        OP_POWER  = 2'd0,
        OP_RATE   = 2'd1,
        OP_DETECT = 2'd2,
        OP_RSVD   = 2'd3
    } pipe_ctrl_op_t;

    // rx_status value reported by the PHY when a receiver was detected.
    localparam logic [2:0] RX_STATUS_RX_PRESENT = 3'b011;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PD_WAIT,
        ST_RATE_WAIT,
        ST_DET_WAIT,
        ST_RESP
    } pipe_ctrl_state_t;

    // States in which the controller is waiting on a phy_status completion.
    function automatic logic is_wait_state(input pipe_ctrl_state_t s);
        return (s == ST_PD_WAIT) || (s == ST_RATE_WAIT) || (s == ST_DET_WAIT);
    endfunction

endpackage

// File: rtl/pipe_pwr_rate_ctrl_if.sv
// LTSSM <-> sequencer command/response channel.
// Ports: req_valid/req_ready/req_op/req_arg (command), rsp_valid/rsp_err/rsp_rx_present
// (one-cycle completion). master = LTSSM side, slave = sequencer side.
interface pipe_pwr_rate_ctrl_if;

    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_arg;
    logic       rsp_valid;
    logic       rsp_err;
    logic       rsp_rx_present;

    modport master (
        output req_valid,
        output req_op,
        output req_arg,
        input  req_ready,
        input  rsp_valid,
        input  rsp_err,
        input  rsp_rx_present
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_arg,
        output req_ready,
        output rsp_valid,
        output rsp_err,
        output rsp_rx_present
    );

endinterface

// File: rtl/pipe_pwr_rate_ctrl_timeout.sv
// phy_status watchdog: loadable down-counter with clear and terminal-count flag.
// Ports: load presets TIMEOUT_CYCLES-1, en decrements, clear zeroes, tc = en and count is zero.
// Loaded on command accept, so tc fires on the TIMEOUT_CYCLES-th wait cycle.
module pipe_phy_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    input  logic clear,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tc = en && (cnt == '0);

endmodule

// File: rtl/pipe_pwr_rate_ctrl.sv
// MAC-side PIPE power-state / rate / receiver-detect sequencer.
// Latency: PHY command accept T -> PIPE change T+1 -> phy_status at S -> rsp_valid S+1;
// rejected or no-change commands respond at T+1. req_ready only in IDLE (one command in flight).
// Ports: clk/reset, ctrl (command/response interface, slave side), phy_ready,
// tx_elec_idle_in (MAC idle request), PIPE outputs power_down/rate/tx_detect_rx/tx_elec_idle,
// PIPE inputs phy_status/rx_status.
module pipe_pwr_rate_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RATE       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_pwr_rate_ctrl_if.slave  ctrl,
    output logic                 phy_ready,
    input  logic [3:0]           tx_elec_idle_in,
    output logic [3:0]           power_down,
    output logic [3:0]           rate,
    output logic                 tx_detect_rx,
    output logic [3:0]           tx_elec_idle,
    input  logic                 phy_status,
    input  logic [2:0]           rx_status
);

    localparam logic [3:0] MAX_RATE_L = 4'(MAX_RATE);

    pipe_ctrl_state_t state_q, state_d;
    logic [3:0]       power_down_q, power_down_d;
    logic [3:0]       rate_q, rate_d;
    logic             tx_detect_rx_q, tx_detect_rx_d;
    logic             phy_ready_q, phy_ready_d;
    logic             err_q, err_d;
    logic             rx_present_q, rx_present_d;

    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_clear;
    logic             tmr_tc;

    pipe_ctrl_op_t    op;
    logic [3:0]       arg;

    assign op  = pipe_ctrl_op_t'(ctrl.req_op);
    assign arg = ctrl.req_arg;

    pipe_phy_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .en    (tmr_en),
        .clear (tmr_clear),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_INIT;
            power_down_q   <= P1;
            rate_q         <= 4'd0;
            tx_detect_rx_q <= 1'b0;
            phy_ready_q    <= 1'b0;
            err_q          <= 1'b0;
            rx_present_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            power_down_q   <= power_down_d;
            rate_q         <= rate_d;
            tx_detect_rx_q <= tx_detect_rx_d;
            phy_ready_q    <= phy_ready_d;
            err_q          <= err_d;
            rx_present_q   <= rx_present_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        power_down_d   = power_down_q;
        rate_d         = rate_q;
        tx_detect_rx_d = tx_detect_rx_q;
        phy_ready_d    = phy_ready_q;
        err_d          = err_q;
        rx_present_d   = rx_present_q;
        tmr_load       = 1'b0;
        tmr_en         = 1'b0;
        tmr_clear      = 1'b0;

        case (state_q)
            // The PHY holds phy_status high until its PLL locks; one low sample releases us.
            ST_INIT: begin
                if (!phy_status) begin
                    phy_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            // Every accepted command leaves IDLE; the default target is an immediate response.
            ST_IDLE: begin
                if (ctrl.req_valid) begin
                    state_d      = ST_RESP;
                    err_d        = 1'b0;
                    rx_present_d = 1'b0;
                    case (op)
                        OP_POWER: begin
                            if (arg > P2) begin
                                err_d = 1'b1;
                            end else if (arg != power_down_q) begin
                                power_down_d = arg;
                                tmr_load     = 1'b1;
                                state_d      = ST_PD_WAIT;
                            end
                        end
                        OP_RATE: begin
                            // Rate changes are only legal in P0 with the transmitter fully idle.
                            if ((arg > MAX_RATE_L) || (power_down_q != P0) ||
                                (tx_elec_idle_in != 4'hF)) begin
                                err_d = 1'b1;
                            end else if (arg != rate_q) begin
                                rate_d   = arg;
                                tmr_load = 1'b1;
                                state_d  = ST_RATE_WAIT;
                            end
                        end
                        OP_DETECT: begin
                            if (power_down_q != P1) begin
                                err_d = 1'b1;
                            end else begin
                                tx_detect_rx_d = 1'b1;
                                tmr_load       = 1'b1;
                                state_d        = ST_DET_WAIT;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end

            // phy_status is checked before the terminal count so a last-cycle completion wins.
            ST_PD_WAIT, ST_RATE_WAIT, ST_DET_WAIT: begin
                tmr_en = 1'b1;
                if (phy_status) begin
                    state_d        = ST_RESP;
                    err_d          = 1'b0;
                    tx_detect_rx_d = 1'b0;
                    rx_present_d   = (state_q == ST_DET_WAIT) &&
                                     (rx_status == RX_STATUS_RX_PRESENT);
                end else if (tmr_tc) begin
                    // The new power_down/rate value is left applied on timeout.
                    state_d        = ST_RESP;
                    err_d          = 1'b1;
                    tx_detect_rx_d = 1'b0;
                    rx_present_d   = 1'b0;
                end
            end

            ST_RESP: begin
                tmr_clear = 1'b1;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign ctrl.req_ready      = (state_q == ST_IDLE);
    assign ctrl.rsp_valid      = (state_q == ST_RESP);
    assign ctrl.rsp_err        = (state_q == ST_RESP) && err_q;
    assign ctrl.rsp_rx_present = (state_q == ST_RESP) && rx_present_q;

    assign phy_ready    = phy_ready_q;
    assign power_down   = power_down_q;
    assign rate         = rate_q;
    assign tx_detect_rx = tx_detect_rx_q;

    // Transmitter is forced idle outside P0 and throughout receiver detection.
    assign tx_elec_idle = ((power_down_q != P0) || (state_q == ST_DET_WAIT)) ?
                          4'hF : tx_elec_idle_in;

endmodule

// File: tb/tb_pipe_pwr_rate_ctrl.sv
module tb_pipe_pwr_rate_ctrl;
    import pipe_pkg::*;

    localparam int TO = 16;

    typedef struct packed {
        logic err;
        logic rxp;
    } rsp_exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       phy_ready;
    logic [3:0] tx_elec_idle_in = 4'h0;
    logic [3:0] power_down;
    logic [3:0] rate;
    logic       tx_detect_rx;
    logic [3:0] tx_elec_idle;
    logic       phy_status = 1'b1;
    logic [2:0] rx_status = 3'b000;

    int checks = 0;
    int failures = 0;
    rsp_exp_t exp_q[$];

    pipe_pwr_rate_ctrl_if ctrl_if ();

    pipe_pwr_rate_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .MAX_RATE       (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ctrl            (ctrl_if),
        .phy_ready       (phy_ready),
        .tx_elec_idle_in (tx_elec_idle_in),
        .power_down      (power_down),
        .rate            (rate),
        .tx_detect_rx    (tx_detect_rx),
        .tx_elec_idle    (tx_elec_idle),
        .phy_status      (phy_status),
        .rx_status       (rx_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard: pops an expectation for every rsp_valid pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (ctrl_if.rsp_valid) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL rsp_unexpected observed=rsp_valid expected=no_response");
                end
                if (exp_q.size() != 0) begin
                    rsp_exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_err", ctrl_if.rsp_err, e.err);
                    chk("rsp_rx_present", ctrl_if.rsp_rx_present, e.rxp);
                end
            end else begin
                chk("rsp_qual_idle", {ctrl_if.rsp_err, ctrl_if.rsp_rx_present}, 2'b00);
            end
        end
    end

    // Drive a command in an IDLE cycle; returns in cycle T+1.
    task automatic send(input logic [1:0] op, input logic [3:0] arg,
                        input logic e, input logic r);
        rsp_exp_t x;
        chk("req_ready_before_send", ctrl_if.req_ready, 1'b1);
        ctrl_if.req_valid = 1'b1;
        ctrl_if.req_op    = op;
        ctrl_if.req_arg   = arg;
        x.err = e;
        x.rxp = r;
        exp_q.push_back(x);
        tick();
        ctrl_if.req_valid = 1'b0;
    endtask

    // Command that must be answered at T+1 with no PHY handshake.
    task automatic imm(input logic [1:0] op, input logic [3:0] arg, input logic e);
        send(op, arg, e, 1'b0);
        chk("imm_rsp_valid", ctrl_if.rsp_valid, 1'b1);
        chk("imm_tx_detect_rx", tx_detect_rx, 1'b0);
        tick();
        chk("imm_ready_after", ctrl_if.req_ready, 1'b1);
    endtask

    // From T+1: `delay` quiet cycles, then a phy_status pulse; checks S+1 and S+2.
    task automatic wait_phy(input int delay, input logic [2:0] rxs, input logic det);
        repeat (delay) begin
            chk("wait_no_rsp", ctrl_if.rsp_valid, 1'b0);
            chk("wait_ready_low", ctrl_if.req_ready, 1'b0);
            chk("wait_tx_detect_rx", tx_detect_rx, det);
            tick();
        end
        chk("s_tx_detect_rx", tx_detect_rx, det);
        phy_status = 1'b1;
        rx_status  = rxs;
        tick();
        phy_status = 1'b0;
        rx_status  = 3'b000;
        chk("rsp_at_s_plus_1", ctrl_if.rsp_valid, 1'b1);
        chk("det_dropped_after_s", tx_detect_rx, 1'b0);
        tick();
        chk("ready_at_s_plus_2", ctrl_if.req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_if.req_valid = 1'b0;
        ctrl_if.req_op    = 2'd0;
        ctrl_if.req_arg   = 4'd0;
        repeat (3) tick();

        // Reset values.
        chk("rst_power_down", power_down, 4'd2);
        chk("rst_rate", rate, 4'd0);
        chk("rst_tx_detect_rx", tx_detect_rx, 1'b0);
        chk("rst_tx_elec_idle", tx_elec_idle, 4'hF);
        chk("rst_req_ready", ctrl_if.req_ready, 1'b0);
        chk("rst_rsp_valid", ctrl_if.rsp_valid, 1'b0);
        chk("rst_phy_ready", phy_ready, 1'b0);

        // Post-reset PHY readiness: phy_status high for 20 cycles.
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("init_phy_ready", phy_ready, 1'b0);
            chk("init_req_ready", ctrl_if.req_ready, 1'b0);
            chk("init_power_down", power_down, 4'd2);
            chk("init_tx_elec_idle", tx_elec_idle, 4'hF);
        end
        phy_status = 1'b0;
        chk("init_not_yet_ready", phy_ready, 1'b0);
        tick();
        chk("phy_ready_rise", phy_ready, 1'b1);
        chk("idle_req_ready", ctrl_if.req_ready, 1'b1);

        // POWER -> P0 with completion five cycles after accept.
        tx_elec_idle_in = 4'h0;
        send(OP_POWER, 4'd0, 1'b0, 1'b0);
        chk("pd_p0_at_t1", power_down, 4'd0);
        chk("pd_ready_low", ctrl_if.req_ready, 1'b0);
        wait_phy(4, 3'b000, 1'b0);
        chk("eidle_follows_0", tx_elec_idle, 4'h0);
        tx_elec_idle_in = 4'h5;
        #1;
        chk("eidle_follows_5", tx_elec_idle, 4'h5);

        // Rate changes.
        tx_elec_idle_in = 4'hF;
        send(OP_RATE, 4'd4, 1'b0, 1'b0);
        chk("rate_4_at_t1", rate, 4'd4);
        wait_phy(2, 3'b000, 1'b0);
        imm(OP_RATE, 4'd5, 1'b1);
        chk("rate_unchanged_bad_arg", rate, 4'd4);
        tx_elec_idle_in = 4'h0;
        imm(OP_RATE, 4'd3, 1'b1);
        chk("rate_unchanged_not_idle", rate, 4'd4);
        tx_elec_idle_in = 4'hF;
        imm(OP_RATE, 4'd4, 1'b0);
        imm(OP_RSVD, 4'd0, 1'b1);
        imm(OP_POWER, 4'd4, 1'b1);
        chk("pd_unchanged_bad_arg", power_down, 4'd0);
        imm(OP_POWER, 4'd0, 1'b0);
        imm(OP_DETECT, 4'd0, 1'b1);

        // Receiver detect from P1, present and absent.
        send(OP_POWER, 4'd2, 1'b0, 1'b0);
        chk("pd_p1_at_t1", power_down, 4'd2);
        wait_phy(1, 3'b000, 1'b0);
        send(OP_DETECT, 4'd0, 1'b0, 1'b1);
        chk("det_eidle_forced", tx_elec_idle, 4'hF);
        wait_phy(3, 3'b011, 1'b1);
        send(OP_DETECT, 4'd9, 1'b0, 1'b0);
        wait_phy(2, 3'b000, 1'b1);

        // Timeout: no phy_status for TO wait cycles.
        send(OP_POWER, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < TO; i++) begin
            chk("to_no_rsp", ctrl_if.rsp_valid, 1'b0);
            tick();
        end
        chk("to_rsp_valid", ctrl_if.rsp_valid, 1'b1);
        chk("to_power_down_kept", power_down, 4'd3);
        tick();
        chk("to_ready_after", ctrl_if.req_ready, 1'b1);

        // phy_status on the terminal cycle beats the timeout.
        send(OP_POWER, 4'd2, 1'b0, 1'b0);
        wait_phy(TO - 1, 3'b000, 1'b0);
        chk("tc_race_power_down", power_down, 4'd2);

        // Reset during RATE_WAIT.
        send(OP_POWER, 4'd0, 1'b0, 1'b0);
        wait_phy(1, 3'b000, 1'b0);
        send(OP_RATE, 4'd2, 1'b0, 1'b0);
        chk("rw_rate_2", rate, 4'd2);
        tick();
        phy_status = 1'b1;
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_power_down", power_down, 4'd2);
        chk("mid_rst_rate", rate, 4'd0);
        chk("mid_rst_eidle", tx_elec_idle, 4'hF);
        chk("mid_rst_ready", ctrl_if.req_ready, 1'b0);
        chk("mid_rst_rsp_valid", ctrl_if.rsp_valid, 1'b0);
        chk("mid_rst_phy_ready", phy_ready, 1'b0);
        tick();
        reset = 1'b0;
        repeat (4) begin
            tick();
            chk("reinit_no_rsp", ctrl_if.rsp_valid, 1'b0);
            chk("reinit_ready_low", ctrl_if.req_ready, 1'b0);
        end
        phy_status = 1'b0;
        tick();
        chk("reinit_phy_ready", phy_ready, 1'b1);
        chk("reinit_req_ready", ctrl_if.req_ready, 1'b1);
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
